vending_machine: RTL and testbench

//   Coin-operated vending controller. Accumulates credit from two coin inputs,

---
 rtl/vending_machine.sv | 74 +++++++
 tb/tb_vending_machine.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// Coin vending controller: accumulates credit from coins a/b, vends at PRICE,
// returns excess as change. Optional refund via `VM_REFUND_EN (adds cancel).
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   cancel - refund request (only when VM_REFUND_EN is defined)
//   a      - coin a present this cycle (worth A_VAL)
//   b      - coin b present this cycle (worth B_VAL)
//   change - change returned in credit units (registered)
//   out    - one-cycle dispense pulse per item (registered)
module vending_machine #(
    parameter int PRICE = 3,
    parameter int A_VAL = 1,
    parameter int B_VAL = 2,
    parameter int CW    = 4
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VM_REFUND_EN
    input  logic       cancel,
`endif
    input  logic       a,
    input  logic       b,
    output logic [2:0] change,
    output logic       out
);

    if (2**CW <= PRICE - 1 + A_VAL + B_VAL) begin : g_cw_chk
        $error("vending_machine: CW too narrow for PRICE-1+A_VAL+B_VAL");
    end

    logic [CW-1:0] credit_q, credit_d;
    logic [2:0]    change_q, change_d;
    logic          out_q, out_d;
    logic [CW-1:0] sum;

    always_comb begin
        sum      = credit_q
                 + (a ? CW'(A_VAL) : '0)
                 + (b ? CW'(B_VAL) : '0);
        credit_d = sum;
        change_d = '0;
        out_d    = 1'b0;
`ifdef VM_REFUND_EN
        // Refund wins over a sale completing in the same cycle.
        if (cancel) begin
            change_d = 3'(sum);
            credit_d = '0;
        end else
`endif
        if (sum >= CW'(PRICE)) begin
            out_d    = 1'b1;
            change_d = 3'(sum - CW'(PRICE));
            credit_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q <= '0;
            change_q <= '0;
            out_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            change_q <= change_d;
            out_q    <= out_d;
        end
    end

    assign change = change_q;
    assign out    = out_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine.
// Drives inputs on falling edges, checks 1ns after rising edges.
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       cancel;
    logic [2:0] change;
    logic       out;

    int tests;
    int fails;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
`ifdef VM_REFUND_EN
        .cancel (cancel),
`endif
        .a      (a),
        .b      (b),
        .change (change),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic ia, input logic ib, input logic ic);
        @(negedge clk);
        a      = ia;
        b      = ib;
        cancel = ic;
        @(posedge clk);
        #1;
        a      = 1'b0;
        b      = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic check(input string tag, input logic eo,
                         input logic [2:0] ec);
        tests++;
        assert (out === eo) else begin
            fails++;
            $error("FAIL %s out=%b expected %b", tag, out, eo);
        end
        tests++;
        assert (change === ec) else begin
            fails++;
            $error("FAIL %s change=%0d expected %0d", tag, change, ec);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        a      = 1'b0;
        b      = 1'b0;
        cancel = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        step(0, 0, 0); check("idle", 0, 0);

        step(1, 0, 0); check("aab_a1", 0, 0);
        step(1, 0, 0); check("aab_a2", 0, 0);
        step(0, 1, 0); check("aab_b", 1, 1);
        step(0, 0, 0); check("aab_idle", 0, 0);

        step(0, 1, 0); check("bb_b1", 0, 0);
        step(0, 1, 0); check("bb_b2", 1, 1);

        step(1, 0, 0); check("s6_a1", 0, 0);
        step(1, 0, 0); check("s6_a2", 0, 0);
        step(1, 0, 0); check("s6_a3", 1, 0);
        step(1, 0, 0); check("s6_a4", 0, 0);
        step(0, 1, 0); check("s6_b1", 1, 0);
        step(0, 1, 0); check("s6_b2", 0, 0);

        // credit is 2 here
        step(1, 1, 0); check("c2_ab", 1, 2);
        step(1, 1, 0); check("c0_ab", 1, 0);
        step(1, 1, 0); check("b2b_ab", 1, 0);
        step(0, 0, 0); check("b2b_idle", 0, 0);

        // level held high for three edges counts three coins
        @(negedge clk);
        a = 1'b1;
        @(posedge clk); #1; check("hold_1", 0, 0);
        @(posedge clk); #1; check("hold_2", 0, 0);
        @(posedge clk); #1; check("hold_3", 1, 0);
        @(negedge clk);
        a = 1'b0;
        @(posedge clk); #1; check("hold_idle", 0, 0);

        // async reset clears registered outputs immediately
        step(0, 1, 0);
        step(0, 1, 0); check("rst_pre", 1, 1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_async_out", 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-accumulation discards credit
        step(0, 1, 0); check("rst_c2", 0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0); check("post_rst_a1", 0, 0);
        step(1, 0, 0); check("post_rst_a2", 0, 0);
        step(1, 0, 0); check("post_rst_a3", 1, 0);

`ifdef VM_REFUND_EN
        step(0, 1, 0); check("ref_c2", 0, 0);
        step(0, 0, 1); check("ref_cancel", 0, 2);
        step(1, 0, 0); check("ref_after", 0, 0);
        step(1, 0, 0); check("ref_c2b", 0, 0);
        step(1, 0, 1); check("ref_prio", 0, 3);
        step(0, 0, 0); check("ref_idle", 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
